// File: rtl/line_doubler.sv
// ---------------------------------------------------------------------------
// line_doubler
//
// Two-bank line buffer and 2x scaler in front of the HDMI output stage.
// One source line is written into the bank that is not being displayed while
// the other bank is shown as 2x2 pixel blocks inside a window positioned by
// H_OFFSET/V_OFFSET. Pixels outside that window are BORDER_RGB.
//
// Ports
//   clk_pixel       pixel clock, all logic on the rising edge
//   reset_n         asynchronous active-low reset
//   src_line_start  one-cycle pulse at the start of a source line
//   src_valid       src_rgb carries a pixel this cycle
//   src_rgb         source pixel {R,G,B}
//   src_ready       high when a new line can be accepted (write bank free)
//   cx, cy          HDMI frame column / row counters
//   rgb             registered output pixel, 2 cycles after cx/cy
//   overflow        sticky: a line was dropped because a line was pending
//   underrun        sticky: a line pair started with nothing pending
// ---------------------------------------------------------------------------
module line_doubler #(
    parameter int          SRC_WIDTH  = 320,
    parameter int          SRC_LINES  = 240,
    parameter int          H_OFFSET   = 2,
    parameter int          V_OFFSET   = 0,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        src_line_start,
    input  logic        src_valid,
    input  logic [23:0] src_rgb,
    output logic        src_ready,
    input  logic [10:0] cx,
    input  logic [9:0]  cy,
    output logic [23:0] rgb,
    output logic        overflow,
    output logic        underrun
);

    localparam int                ADDR_W = $clog2(SRC_WIDTH);
    localparam logic [10:0]       H_OFF  = 11'(H_OFFSET);
    localparam logic [10:0]       WIN_W  = 11'(2 * SRC_WIDTH);
    localparam logic [9:0]        V_OFF  = 10'(V_OFFSET);
    localparam logic [9:0]        WIN_H  = 10'(2 * SRC_LINES);
    localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(SRC_WIDTH - 1);

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_e;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_x_q, wr_x_d;
    logic              pending_q, pending_d;
    logic              rd_bank_q, rd_bank_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              commit;
    logic              accept;
    logic [ADDR_W-1:0] base_x;

    // ------------------------------------------------------------------
    // Window decode. Subtracting the offset first turns each two-sided
    // range check into one unsigned compare: positions before the offset
    // wrap to large values and fall outside the window.
    // ------------------------------------------------------------------
    logic [10:0]       cx_rel;
    logic [9:0]        cy_rel;
    logic              col_win;
    logic              row_win;
    logic              swap;
    logic [ADDR_W-1:0] rd_addr;

    assign cx_rel  = cx - H_OFF;
    assign cy_rel  = cy - V_OFF;
    assign col_win = (cx_rel < WIN_W);
    assign row_win = (cy_rel < WIN_H);
    // Banks change only at the start of an even window row, so the odd row
    // that follows re-reads the same bank (vertical doubling).
    assign swap    = (cx == 11'd0) && row_win && !cy_rel[0];
    // Halving the column gives horizontal doubling.
    assign rd_addr = cx_rel[ADDR_W:1];

    // ------------------------------------------------------------------
    // Write FSM and bank bookkeeping
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_x_d     = wr_x_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_addr    = wr_x_q;
        commit     = 1'b0;
        accept     = 1'b0;
        base_x     = wr_x_q;

        case (state_q)
            W_IDLE: begin
                if (src_line_start) begin
                    if (pending_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        accept = 1'b1;
                        base_x = '0;
                    end
                end
            end
            W_FILL: begin
                accept = 1'b1;
                // A new line start abandons the partial line.
                if (src_line_start) begin
                    base_x = '0;
                end
            end
            default: state_d = W_IDLE;
        endcase

        if (accept) begin
            state_d = W_FILL;
            wr_x_d  = base_x;
            wr_addr = base_x;
            if (src_valid) begin
                wr_en = 1'b1;
                if (base_x == LAST_X) begin
                    commit  = 1'b1;
                    state_d = W_IDLE;
                    wr_x_d  = '0;
                end else begin
                    wr_x_d = base_x + 1'b1;
                end
            end
        end

        // The swap looks only at the registered pending flag, so a commit in
        // the same cycle is not visible to it; the commit still lands.
        rd_bank_d  = rd_bank_q ^ (swap && pending_q);
        underrun_d = underrun_q | (swap && !pending_q);
        pending_d  = pending_q;
        if (swap && pending_q) begin
            pending_d = 1'b0;
        end
        if (commit) begin
            pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= W_IDLE;
            wr_x_q     <= '0;
            pending_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_x_q     <= wr_x_d;
            pending_q  <= pending_d;
            rd_bank_q  <= rd_bank_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Line storage: bank rd_bank_q is displayed, the other one is written,
    // so a read and a write never target the same bank.
    // ------------------------------------------------------------------
    logic [23:0] mem [0:1][0:SRC_WIDTH-1];

    // NOTE: the memory has no reset; its contents are only meaningful once
    // a committed line has been swapped in, so clearing it buys nothing.
    always_ff @(posedge clk_pixel) begin
        if (wr_en) begin
            mem[!rd_bank_q][wr_addr] <= src_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Two-stage read pipeline. The 2-cycle latency is absorbed by H_OFFSET.
    // ------------------------------------------------------------------
    logic              in_win_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [23:0]       rgb_q;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            in_win_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            in_win_q  <= col_win && row_win;
            // Outside the window the address is parked at 0 so the read
            // index always stays inside the bank.
            rd_addr_q <= (col_win && row_win) ? rd_addr : '0;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 24'h000000;
        end else if (in_win_q) begin
            rgb_q <= mem[rd_bank_q][rd_addr_q];
        end else begin
            rgb_q <= BORDER_RGB;
        end
    end

    assign src_ready = !pending_q;
    assign rgb       = rgb_q;
    assign overflow  = overflow_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_line_doubler.sv
// ---------------------------------------------------------------------------
// tb_line_doubler
//
// Directed bench for line_doubler with default parameters (320 pixels,
// H_OFFSET=2, V_OFFSET=0, black border). Source lines are built from small
// pattern functions; each scanned row is compared pixel by pixel against
// the pattern expected in the displayed bank.
// ---------------------------------------------------------------------------
module tb_line_doubler;

    localparam int          SRC_WIDTH = 320;
    localparam int          H_OFFSET  = 2;
    localparam logic [23:0] BORDER    = 24'h000000;

    logic        clk_pixel      = 1'b0;
    logic        reset_n        = 1'b1;
    logic        src_line_start = 1'b0;
    logic        src_valid      = 1'b0;
    logic [23:0] src_rgb        = 24'h0;
    logic [10:0] cx             = 11'd700;
    logic [9:0]  cy             = 10'd0;
    logic        src_ready;
    logic [23:0] rgb;
    logic        overflow;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    line_doubler dut (
        .clk_pixel     (clk_pixel),
        .reset_n       (reset_n),
        .src_line_start(src_line_start),
        .src_valid     (src_valid),
        .src_rgb       (src_rgb),
        .src_ready     (src_ready),
        .cx            (cx),
        .cy            (cy),
        .rgb           (rgb),
        .overflow      (overflow),
        .underrun      (underrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Source line patterns.
    function automatic logic [23:0] pat_pix(input int pat, input int i);
        case (pat)
            0:       return 24'(i * 3);
            1:       return 24'h100000 + 24'(i);
            2:       return 24'h555555 ^ 24'(i);
            3:       return 24'h123456 + 24'(i);
            4:       return 24'hFFFFFF;
            default: return 24'h00AA00 + 24'(i);
        endcase
    endfunction

    // Expected rgb for frame column p when bank content is pattern pat.
    function automatic logic [23:0] exp_rgb(input int pat, input int p);
        if (p >= H_OFFSET && p < H_OFFSET + 2 * SRC_WIDTH)
            return pat_pix(pat, (p - H_OFFSET) / 2);
        return BORDER;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Drive n pixels of pattern pat starting at index first.
    task automatic write_pixels(input int pat, input int first, input int n, input bit start);
        for (int i = first; i < first + n; i++) begin
            src_line_start = start && (i == first);
            src_valid      = 1'b1;
            src_rgb        = pat_pix(pat, i);
            tick();
        end
        src_line_start = 1'b0;
        src_valid      = 1'b0;
    endtask

    // Scan one frame row from column first_c to 799. After the tick that
    // presents column c, rgb reflects column c-1 (two-stage pipeline).
    task automatic run_row(input int row, input int first_c, input int pat, input bit chk);
        cy = 10'(row);
        for (int c = first_c; c < 800; c++) begin
            cx = 11'(c);
            tick();
            if (chk && c > first_c)
                check($sformatf("row%0d_cx%0d", row, c - 1), rgb, exp_rgb(pat, c - 1));
        end
        cx = 11'd700;
    endtask

    initial begin
        // ---- reset state -------------------------------------------------
        #1 reset_n = 1'b0;
        #1;
        check("reset_rgb",       rgb,            24'h000000);
        check("reset_src_ready", 24'(src_ready), 24'd1);
        check("reset_overflow",  24'(overflow),  24'd0);
        check("reset_underrun",  24'(underrun),  24'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ---- line of index*3, displayed on rows 0..2 ---------------------
        write_pixels(0, 0, SRC_WIDTH - 1, 1'b1);
        check("no_commit_before_last", 24'(src_ready), 24'd1);
        write_pixels(0, SRC_WIDTH - 1, 1, 1'b0);
        check("pending_after_line", 24'(src_ready), 24'd0);
        run_row(0, 0, 0, 1'b1);
        check("pending_cleared_by_swap", 24'(src_ready), 24'd1);
        check("no_underrun_row0",        24'(underrun),  24'd0);
        run_row(1, 0, 0, 1'b1);
        check("no_underrun_odd_row",     24'(underrun),  24'd0);
        run_row(2, 0, 0, 1'b1);
        check("underrun_row2",           24'(underrun),  24'd1);

        // ---- overflow: third line start while a line is pending ----------
        write_pixels(1, 0, SRC_WIDTH, 1'b1);
        check("line2_pending",       24'(src_ready), 24'd0);
        check("overflow_before",     24'(overflow),  24'd0);
        write_pixels(2, 0, SRC_WIDTH, 1'b1);
        check("overflow_set",        24'(overflow),  24'd1);
        check("still_pending",       24'(src_ready), 24'd0);
        run_row(4, 0, 1, 1'b1);
        check("line2_swapped",       24'(src_ready), 24'd1);

        // ---- abandoned partial line, then a full white line --------------
        write_pixels(3, 0, 100, 1'b1);
        check("partial_no_commit",   24'(src_ready), 24'd1);
        write_pixels(4, 0, SRC_WIDTH - 1, 1'b1);
        check("restart_no_early_commit", 24'(src_ready), 24'd1);
        write_pixels(4, SRC_WIDTH - 1, 1, 1'b0);
        check("white_pending",       24'(src_ready), 24'd0);
        run_row(6, 0, 4, 1'b1);

        // ---- asynchronous reset in the middle of a fill ------------------
        cy = 10'd7;
        cx = 11'd10;
        write_pixels(5, 0, 5, 1'b1);
        check("pre_reset_rgb", rgb, 24'hFFFFFF);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_rgb",       rgb,            24'h000000);
        check("async_reset_src_ready", 24'(src_ready), 24'd1);
        check("async_reset_overflow",  24'(overflow),  24'd0);
        check("async_reset_underrun",  24'(underrun),  24'd0);
        tick();
        tick();
        reset_n = 1'b1;
        cx = 11'd700;
        cy = 10'd0;
        tick();

        // ---- last-pixel commit in the same cycle as a swap ---------------
        write_pixels(5, 0, SRC_WIDTH - 1, 1'b1);
        check("pre_commit_ready",    24'(src_ready), 24'd1);
        check("pre_commit_underrun", 24'(underrun),  24'd0);
        cx        = 11'd0;
        cy        = 10'd0;
        src_valid = 1'b1;
        src_rgb   = pat_pix(5, SRC_WIDTH - 1);
        tick();
        src_valid = 1'b0;
        check("commit_swap_underrun", 24'(underrun),  24'd1);
        check("commit_swap_pending",  24'(src_ready), 24'd0);
        run_row(0, 1, 5, 1'b0);
        run_row(1, 0, 5, 1'b0);
        run_row(2, 0, 5, 1'b1);
        check("commit_swap_displayed", 24'(src_ready), 24'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
